// File: rtl/seq_mux_n.sv
// N:1 channel selector with a registered output and valid/ready handshake; optional out_par via SEQ_MUX_PARITY_EN.
// One cycle from req to out_valid; while out_valid & ~out_ready the output holds and req is dropped, not queued.
module seq_mux_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 6,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan_mode,
    input  logic                      req,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
`ifdef SEQ_MUX_PARITY_EN
    output logic                      out_par,
`endif
    output logic                      sel_err
);

    typedef enum logic [1:0] {IDLE, FULL, STALL} state_t;

    localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic [SEL_W-1:0]   scan_ptr_q, scan_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;
    logic               out_par_q, out_par_d;

    logic               cap;
    logic               oor;
    logic [SEL_W-1:0]   idx;
    logic [WIDTH-1:0]   mux_dat;

    always_comb begin
        cap = req & (~out_valid_q | out_ready);
        idx = scan_mode ? scan_ptr_q : sel;
        // The scan pointer can never leave range, so only manual selects are checked.
        oor = ~scan_mode & ({1'b0, idx} >= CH_LIM);

        mux_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                mux_dat = data_in[k*WIDTH +: WIDTH];
            end
        end

        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        sel_err_d  = sel_err_q;
        out_par_d  = out_par_q;
        scan_ptr_d = scan_ptr_q;

        if (cap) begin
            if (oor) begin
                out_data_d = '0;
                out_ch_d   = sel;
                sel_err_d  = 1'b1;
                out_par_d  = 1'b0;
            end else begin
                out_data_d = mux_dat;
                out_ch_d   = idx;
                sel_err_d  = 1'b0;
                out_par_d  = ^mux_dat;
            end
            if (scan_mode) begin
                scan_ptr_d = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + SEL_W'(1);
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cap) state_d = FULL;
            end
            FULL, STALL: begin
                if (out_ready) state_d = req ? FULL : IDLE;
                else           state_d = req ? STALL : FULL;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            out_par_q   <= 1'b0;
            scan_ptr_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            out_par_q   <= out_par_d;
            scan_ptr_q  <= scan_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
`ifdef SEQ_MUX_PARITY_EN
    assign out_par   = out_par_q;
`else
    logic unused_par;
    assign unused_par = out_par_q;
`endif

endmodule
